// File: rtl/n8cs_bist_driver_pkg.sv
// Shared types and golden-model helpers for the comparator BIST engine.
package n8cs_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_t;

  // Reference comparator result {ee, gg} for unsigned operands of up to 8 bits.
  function automatic logic [1:0] cmp_golden(input logic [7:0] a, input logic [7:0] b);
    return {a == b, a > b};
  endfunction

  // Increment that sticks at max instead of wrapping.
  function automatic logic [16:0] sat_inc(input logic [16:0] v, input logic [16:0] max);
    return (v == max) ? v : v + 17'd1;
  endfunction

endpackage

// File: rtl/n8cs_bist_driver_if.sv
// Operand/result bundle between the BIST driver and the comparator under test.
interface n8cs_bist_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] aa;
  logic [WIDTH-1:0] bb;
  logic             ee_in;
  logic             gg_in;

  modport master (output aa, output bb, input ee_in, input gg_in);
  modport slave  (input aa, input bb, output ee_in, output gg_in);
endinterface

// File: rtl/n8cs_bist_checker.sv
// Compares the comparator's answer with the golden model; X/Z counts as wrong.
module n8cs_bist_checker
  import n8cs_bist_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] aa,
  input  logic [WIDTH-1:0] bb,
  input  logic             ee_in,
  input  logic             gg_in,
  output logic             mismatch
);
  logic [1:0] gold;

  // Case inequality so an unknown result from the comparator is flagged.
  assign gold     = cmp_golden(8'(aa), 8'(bb));
  assign mismatch = (ee_in !== gold[1]) || (gg_in !== gold[0]);
endmodule

// File: rtl/n8cs_bist_driver.sv
// Sweeps every {aa,bb} pair, holds each for SETTLE_CYCLES, samples and
// scores the comparator, and keeps error count plus the first failing pair.
module n8cs_bist_driver
  import n8cs_bist_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  n8cs_bist_driver_if.master    cmp,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*WIDTH:0]      err_count,
  output logic [WIDTH-1:0]      first_fail_aa,
  output logic [WIDTH-1:0]      first_fail_bb
);
  localparam int CW   = 2*WIDTH + 1;
  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [16:0]     ERR_MAX  = 17'((64'd1 << CW) - 64'd1);

  bist_state_t        state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] vec_q, vec_d;
  logic [CW-1:0]      err_q, err_d;
  logic [WIDTH-1:0]   ff_aa_q, ff_aa_d, ff_bb_q, ff_bb_d;
  logic               fail_seen_q, fail_seen_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               mismatch;

  n8cs_bist_checker #(.WIDTH(WIDTH)) u_checker (
    .aa       (vec_q[2*WIDTH-1:WIDTH]),
    .bb       (vec_q[WIDTH-1:0]),
    .ee_in    (cmp.ee_in),
    .gg_in    (cmp.gg_in),
    .mismatch (mismatch)
  );

  // Next-state: sweep sequencing, error scoring and first-fail capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    err_d       = err_q;
    ff_aa_d     = ff_aa_q;
    ff_bb_d     = ff_bb_q;
    fail_seen_d = fail_seen_q;
    busy_d      = busy_q;
    done_d      = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SETTLE;
          cnt_d       = '0;
          vec_d       = '0;
          err_d       = '0;
          ff_aa_d     = '0;
          ff_bb_d     = '0;
          fail_seen_d = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = CW'(sat_inc(17'(err_q), ERR_MAX));
          if (!fail_seen_q) begin
            ff_aa_d     = vec_q[2*WIDTH-1:WIDTH];
            ff_bb_d     = vec_q[WIDTH-1:0];
            fail_seen_d = 1'b1;
          end
        end
        // Operands hold at all-ones once the sweep completes.
        if (&vec_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          vec_d   = vec_q + (2*WIDTH)'(1);
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      err_q       <= '0;
      ff_aa_q     <= '0;
      ff_bb_q     <= '0;
      fail_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      err_q       <= err_d;
      ff_aa_q     <= ff_aa_d;
      ff_bb_q     <= ff_bb_d;
      fail_seen_q <= fail_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmp.aa        = vec_q[2*WIDTH-1:WIDTH];
  assign cmp.bb        = vec_q[WIDTH-1:0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_q;
  assign first_fail_aa = ff_aa_q;
  assign first_fail_bb = ff_bb_q;
  assign pass          = done_q && (err_q == '0);
endmodule

// File: tb/tb_n8cs_bist_driver.sv
// Directed bench: WIDTH=2, SETTLE_CYCLES=3 against a behavioural comparator
// with selectable faults.
module tb_n8cs_bist_driver;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy, done, pass;
  logic [2*W:0] err_count;
  logic [W-1:0] ff_aa, ff_bb;
  int           mode;    // 0 ideal, 1 gg stuck 0, 2 ee inverted, 3 ee X on 1010
  logic         ee_m, gg_m;
  int           tests = 0;
  int           fails = 0;
  string        phase = "reset";

  n8cs_bist_driver_if #(.WIDTH(W)) cif ();

  n8cs_bist_driver #(.WIDTH(W), .SETTLE_CYCLES(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cmp           (cif.master),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_fail_aa (ff_aa),
    .first_fail_bb (ff_bb)
  );

  always #5 clk = ~clk;

  // Behavioural comparator with fault injection.
  always_comb begin
    ee_m = (cif.aa == cif.bb);
    gg_m = (cif.aa > cif.bb);
    case (mode)
      1: gg_m = 1'b0;
      2: ee_m = ~(cif.aa == cif.bb);
      3: if (cif.aa == 2'b10 && cif.bb == 2'b10) ee_m = 1'bx;
      default: ;
    endcase
  end
  assign cif.ee_in = ee_m;
  assign cif.gg_in = gg_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s.%s got=%0h expected=%0h", phase, tag, got, exp);
    end
  endtask

  // Starts a sweep from IDLE/DONE and follows it to the done edge (edge 64).
  task automatic run_sweep(input bit hold);
    int busy_n;
    start = 1'b1;
    @(posedge clk); #1;
    chk("acc_busy", 32'(busy), 1);
    chk("acc_ab", 32'({cif.aa, cif.bb}), 0);
    chk("acc_err", 32'(err_count), 0);
    if (!hold) start = 1'b0;
    busy_n = busy ? 1 : 0;
    for (int i = 1; i < 64; i++) begin
      @(posedge clk); #1;
      busy_n += busy ? 1 : 0;
    end
    chk("done_e63", 32'(done), 0);
    @(posedge clk); #1;
    chk("done_e64", 32'(done), 1);
    chk("busy_e64", 32'(busy), 0);
    chk("busy_cycles", 32'(busy_n), 64);
    chk("ab_hold", 32'({cif.aa, cif.bb}), 32'hF);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 0;
    @(posedge clk); #1;
    chk("busy", 32'(busy), 0);
    chk("done", 32'(done), 0);
    chk("pass", 32'(pass), 0);
    chk("err", 32'(err_count), 0);
    chk("ab", 32'({cif.aa, cif.bb}), 0);
    rst = 1'b0;

    phase = "ideal";
    run_sweep(1'b0);
    chk("err", 32'(err_count), 0);
    chk("pass", 32'(pass), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("done_stable", 32'(done), 1);
    chk("pass_stable", 32'(pass), 1);

    phase = "gg_stuck0";
    mode = 1;
    run_sweep(1'b0);
    chk("err", 32'(err_count), 6);
    chk("ff_aa", 32'(ff_aa), 1);
    chk("ff_bb", 32'(ff_bb), 0);
    chk("pass", 32'(pass), 0);

    phase = "ee_inv";
    mode = 2;
    run_sweep(1'b0);
    chk("err", 32'(err_count), 16);
    chk("ff_aa", 32'(ff_aa), 0);
    chk("ff_bb", 32'(ff_bb), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_stable", 32'(err_count), 16);

    phase = "mid_reset";
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("err_pre", 32'(err_count), 5);
    rst = 1'b1;
    #1;
    chk("busy", 32'(busy), 0);
    chk("done", 32'(done), 0);
    chk("err", 32'(err_count), 0);
    chk("ab", 32'({cif.aa, cif.bb}), 0);
    chk("ff", 32'({ff_aa, ff_bb}), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 0);
    run_sweep(1'b0);
    chk("err", 32'(err_count), 16);

    phase = "start_held";
    mode = 2;
    run_sweep(1'b1);
    chk("err_e64", 32'(err_count), 16);
    @(posedge clk); #1;
    chk("busy_e65", 32'(busy), 1);
    chk("done_e65", 32'(done), 0);
    chk("err_e65", 32'(err_count), 0);
    chk("ab_e65", 32'({cif.aa, cif.bb}), 0);
    start = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;

    phase = "ee_x";
    mode = 3;
    run_sweep(1'b0);
    chk("err", 32'(err_count), 1);
    chk("ff_aa", 32'(ff_aa), 2);
    chk("ff_bb", 32'(ff_bb), 2);
    chk("pass", 32'(pass), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/n8cs_bist_driver.md
Name: n8cs_bist_driver

Overview:
- On-chip stimulus/check engine for the N-bit iterative comparator: it is the driving end of the comparator interface.
- Sweeps every {aa,bb} pair and holds each pair for a programmable settle time. Samples EE (equal) and GG (aa > bb, unsigned), checks them against a golden model and reports error statistics.
- Sits beside the comparator under test. It replaces file-based vector loading for silicon/FPGA self-test.

Parameters:
- WIDTH, 8, operand width of aa/bb; legal range 1..8.
- SETTLE_CYCLES, 18, cycles each vector is held before sampling; legal range >=1 (18 cycles = 180 ns at 10 ns clock).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled in IDLE or DONE to begin a sweep.
- aa  output  WIDTH  operand A driven to the comparator.
- bb  output  WIDTH  operand B driven to the comparator.
- ee_in  input  1  comparator EE result.
- gg_in  input  1  comparator GG result.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next start is accepted.
- pass  output  1  equals done AND (err_count == 0).
- err_count  output  2*WIDTH+1  number of mismatching vectors; saturates at all-ones.
- first_fail_aa  output  WIDTH  aa of the first mismatching vector.
- first_fail_bb  output  WIDTH  bb of the first mismatching vector.

Behaviour:
- Reset (async, any state): state=IDLE; aa, bb, busy, done, pass, err_count, first_fail_aa and first_fail_bb are all 0; settle counter and fail_seen flag are 0.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered except pass, which is decoded from done and err_count.
- IDLE/DONE with start=1 at an edge -> SETTLE. At that edge: {aa,bb}=0, err_count=0, first_fail=0, fail_seen=0, busy=1, done=0.
- SETTLE: the counter increments each cycle. At counter == SETTLE_CYCLES-1 -> SAMPLE, and the counter clears.
- SAMPLE (one cycle):
  - Golden values: exp_ee = (aa==bb), exp_gg = (aa>bb), unsigned.
  - A mismatch is ee_in !== exp_ee or gg_in !== exp_gg. X/Z on either input counts as a mismatch.
  - On mismatch: err_count increments unless it is already all-ones.
  - On the first mismatch only: first_fail_aa/bb capture aa/bb and fail_seen is set.
- Vector advance:
  - If {aa,bb} is all-ones -> DONE with busy=0, done=1; aa/bb hold their last values.
  - Otherwise {aa,bb} increments as one 2*WIDTH-bit value (bb is the LSB half) -> SETTLE.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. done rises 2^(2*WIDTH)*(SETTLE_CYCLES+1) edges after the start-accept edge.
- start while busy is ignored.
- start held high in DONE restarts a sweep on the next edge.
- Results (err_count, first_fail_*) stay stable throughout DONE.
- Reset mid-sweep aborts immediately to the reset values; no partial results are retained.
- The operands change only on the SAMPLE->SETTLE edge. The comparator therefore sees exactly one transition per vector, so the settle time bounds its worst-case propagation delay.

Decomposition:
- Package n8cs_bist_pkg holds:
  - the state enum type (IDLE, SETTLE, SAMPLE, DONE);
  - the golden function cmp_golden(a,b) returning {ee,gg};
  - a saturating-increment helper.
- Natural sub-module: n8cs_bist_checker. It is combinational: it takes aa, bb, ee_in, gg_in and produces mismatch. It uses the package golden function so benches can reuse it.
- The FSM, counters and capture registers stay in n8cs_bist_driver.

Test Plan:
- WIDTH=2, SETTLE_CYCLES=3, ideal behavioural comparator; start pulsed 1 cycle -> busy high for 64 cycles, done=1 at edge 64, err_count=0, pass=1.
- Same configuration, gg_in stuck at 0 -> err_count=6 (vectors with aa>bb), first_fail_aa=01, first_fail_bb=00, pass=0.
- Same configuration, ee_in inverted -> err_count=16, first_fail_aa=00, first_fail_bb=00.
- Faulty comparator with rst asserted at cycle 20 mid-sweep -> all outputs 0 immediately (async), state IDLE. A new start gives a full 64-cycle sweep from {aa,bb}=0000.
- start held high throughout the sweep -> single sweep, done at edge 64. Because start is still high, a second sweep begins at edge 65 with err_count cleared to 0.
- ee_in driven X on vector {aa,bb}=1010 only -> err_count=1, first_fail_aa=10, first_fail_bb=10.
